sonuc_bcd_donusturucu: RTL and testbench

Downstream stage of the trigonometric result units (sinus, cosinus, kotanjant). Captures a 64-bit unsigned result when its producer raises hazir and gecerli. Converts it to packed BCD with sequential double-dabble, one shift per clock. Holds the digits, a significant-digit count and an error flag for the display driver until acknowledged.

---
 rtl/sonuc_bcd_donusturucu_pkg.sv | 16 +
 rtl/bcd_duzelt.sv | 14 +
 rtl/sonuc_bcd_donusturucu.sv | 119 +++++++++++
 tb/tb_sonuc_bcd_donusturucu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sonuc_bcd_donusturucu_pkg.sv
// Shared definitions for the result-to-BCD conversion stage.
// Latency: none (types and constants only).
// Backpressure: none.
package hesap_paket;

  localparam int VARSAYILAN_VERI_GENISLIGI = 64;
  localparam int VARSAYILAN_BASAMAK        = 20;
  localparam int BASAMAK_GENISLIGI         = 4;

  typedef enum logic [1:0] {
    BOSTA    = 2'd0,
    DONUSTUR = 2'd1,
    BITTI    = 2'd2
  } durum_t;

endpackage

// File: rtl/bcd_duzelt.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: basamak - incoming 4-bit digit; duzeltilmis - corrected digit.
module bcd_duzelt
  import hesap_paket::*;
(
  input  logic [BASAMAK_GENISLIGI-1:0] basamak,
  output logic [BASAMAK_GENISLIGI-1:0] duzeltilmis
);

  assign duzeltilmis = (basamak >= 4'd5) ? basamak + 4'd3 : basamak;

endmodule

// File: rtl/sonuc_bcd_donusturucu.sv
// Captures an unsigned result and converts it to packed BCD (one double-dabble step per clock).
// Latency: bcd_gecerli rises VERI_GENISLIGI edges after the capture edge; same edge for overflow.
// Backpressure: output held until alindi; new start edges ignored while mesgul.
// Ports: clk/rst (async active-high); sonuc/tasma/hazir/gecerli from the math unit;
//        alindi from the display driver; bcd/anlamli_basamak/hata/bcd_gecerli/mesgul to it.
module sonuc_bcd_donusturucu
  import hesap_paket::*;
#(
  parameter int VERI_GENISLIGI = VARSAYILAN_VERI_GENISLIGI,
  parameter int BASAMAK        = VARSAYILAN_BASAMAK
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VERI_GENISLIGI-1:0]            sonuc,
  input  logic                                 tasma,
  input  logic                                 hazir,
  input  logic                                 gecerli,
  input  logic                                 alindi,
  output logic [BASAMAK_GENISLIGI*BASAMAK-1:0] bcd,
  output logic [4:0]                           anlamli_basamak,
  output logic                                 hata,
  output logic                                 bcd_gecerli,
  output logic                                 mesgul
);

  localparam int BCD_W    = BASAMAK_GENISLIGI * BASAMAK;
  localparam int SAYAC_W  = $clog2(VERI_GENISLIGI + 1);

  durum_t                    durum, sonraki_durum;
  logic                      baslat, baslat_q, baslat_yukselen;
  logic [VERI_GENISLIGI-1:0] kaydirma, kaydirma_sonraki;
  logic [BCD_W-1:0]          bcd_acc, duzelt, acc_sonraki;
  logic [SAYAC_W-1:0]        sayac;
  logic                      son_adim;

  // Index of the highest nonzero digit plus one; a zero value still shows one digit.
  function automatic logic [4:0] anlamli_say(input logic [BCD_W-1:0] v);
    logic [4:0] n;
    n = 5'd1;
    for (int i = 0; i < BASAMAK; i++) begin
      if (v[i*BASAMAK_GENISLIGI +: BASAMAK_GENISLIGI] != '0) n = 5'(i + 1);
    end
    return n;
  endfunction

  // The edge register runs in every state so a held level never retriggers.
  assign baslat          = hazir & gecerli;
  assign baslat_yukselen = baslat & ~baslat_q;

  for (genvar g = 0; g < BASAMAK; g++) begin : g_duzelt
    bcd_duzelt u_duzelt (
      .basamak     (bcd_acc[g*BASAMAK_GENISLIGI +: BASAMAK_GENISLIGI]),
      .duzeltilmis (duzelt[g*BASAMAK_GENISLIGI +: BASAMAK_GENISLIGI])
    );
  end

  // Correct first, then shift {bcd_acc, kaydirma} left by one.
  assign acc_sonraki      = {duzelt[BCD_W-2:0], kaydirma[VERI_GENISLIGI-1]};
  assign kaydirma_sonraki = {kaydirma[VERI_GENISLIGI-2:0], 1'b0};
  assign son_adim         = (sayac == SAYAC_W'(VERI_GENISLIGI - 1));

  always_comb begin
    sonraki_durum = durum;
    case (durum)
      BOSTA:    if (baslat_yukselen) sonraki_durum = tasma ? BITTI : DONUSTUR;
      DONUSTUR: if (son_adim)        sonraki_durum = BITTI;
      BITTI:    if (alindi)          sonraki_durum = BOSTA;
      default:                       sonraki_durum = BOSTA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum           <= BOSTA;
      baslat_q        <= 1'b0;
      kaydirma        <= '0;
      bcd_acc         <= '0;
      sayac           <= '0;
      bcd             <= '0;
      anlamli_basamak <= '0;
      hata            <= 1'b0;
    end else begin
      durum    <= sonraki_durum;
      baslat_q <= baslat;
      case (durum)
        BOSTA: begin
          if (baslat_yukselen) begin
            if (tasma) begin
              bcd             <= '0;
              anlamli_basamak <= '0;
              hata            <= 1'b1;
            end else begin
              kaydirma <= sonuc;
              bcd_acc  <= '0;
              sayac    <= '0;
            end
          end
        end
        DONUSTUR: begin
          // The top digit can never carry out when 10^BASAMAK > 2^VERI_GENISLIGI.
          assert (duzelt[BCD_W-1] == 1'b0);
          bcd_acc  <= acc_sonraki;
          kaydirma <= kaydirma_sonraki;
          sayac    <= sayac + SAYAC_W'(1);
          if (son_adim) begin
            bcd             <= acc_sonraki;
            anlamli_basamak <= anlamli_say(acc_sonraki);
            hata            <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd_gecerli = (durum == BITTI);
  assign mesgul      = (durum != BOSTA);

endmodule

// File: tb/tb_sonuc_bcd_donusturucu.sv
module tb_sonuc_bcd_donusturucu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sonuc = '0;
  logic        tasma = 1'b0;
  logic        hazir = 1'b0;
  logic        gecerli = 1'b0;
  logic        alindi = 1'b0;
  logic [79:0] bcd;
  logic [4:0]  anlamli_basamak;
  logic        hata, bcd_gecerli, mesgul;

  sonuc_bcd_donusturucu dut (
    .clk             (clk),
    .rst             (rst),
    .sonuc           (sonuc),
    .tasma           (tasma),
    .hazir           (hazir),
    .gecerli         (gecerli),
    .alindi          (alindi),
    .bcd             (bcd),
    .anlamli_basamak (anlamli_basamak),
    .hata            (hata),
    .bcd_gecerli     (bcd_gecerli),
    .mesgul          (mesgul)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] b;
    logic [4:0]  n;
    logic        h;
  } beklenen_t;

  beklenen_t kuyruk[$];
  int toplam = 0;
  int gecen  = 0;

  task automatic check(input string ad, input logic [79:0] got, input logic [79:0] want);
    toplam++;
    if (got === want) gecen++;
    else $display("FAIL %s: got %h expected %h", ad, got, want);
  endtask

  // Monitor: pops one expectation on every rising edge of bcd_gecerli.
  logic onceki = 1'b0;
  always @(negedge clk) begin
    beklenen_t e;
    if (rst) begin
      onceki = 1'b0;
    end else begin
      if (bcd_gecerli && !onceki) begin
        if (kuyruk.size() == 0) begin
          check("unexpected_result", 80'(bcd_gecerli), 80'd0);
        end else begin
          e = kuyruk.pop_front();
          check("mon_bcd", bcd, e.b);
          check("mon_anlamli", 80'(anlamli_basamak), 80'(e.n));
          check("mon_hata", 80'(hata), 80'(e.h));
        end
      end
      onceki = bcd_gecerli;
    end
  end

  task automatic push(input logic [79:0] b, input logic [4:0] n, input logic h);
    beklenen_t e;
    e.b = b; e.n = n; e.h = h;
    kuyruk.push_back(e);
  endtask

  // One-cycle start pulse; returns #1 after the capture edge.
  task automatic pulse(input logic [63:0] v, input logic t);
    @(negedge clk);
    sonuc = v; tasma = t; hazir = 1'b1; gecerli = 1'b1;
    @(posedge clk); #1;
    hazir = 1'b0; gecerli = 1'b0; tasma = 1'b0;
  endtask

  // Edges after capture until bcd_gecerli, and samples with mesgul high before it.
  task automatic wait_valid(output int n, output int m);
    n = 0; m = 0;
    if (mesgul && !bcd_gecerli) m++;
    while (!bcd_gecerli && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mesgul && !bcd_gecerli) m++;
    end
  endtask

  task automatic ack();
    @(negedge clk); alindi = 1'b1;
    @(posedge clk); #1; alindi = 1'b0;
    check("ack_gecerli_low", 80'(bcd_gecerli), 80'd0);
    check("ack_mesgul_low", 80'(mesgul), 80'd0);
  endtask

  initial begin
    int n, m, donusum;
    logic prev, acked;

    #3;
    check("rst_bcd", bcd, 80'd0);
    check("rst_anlamli", 80'(anlamli_basamak), 80'd0);
    check("rst_hata", 80'(hata), 80'd0);
    check("rst_gecerli", 80'(bcd_gecerli), 80'd0);
    check("rst_mesgul", 80'(mesgul), 80'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero value
    push(80'h0, 5'd1, 1'b0);
    pulse(64'd0, 1'b0);
    wait_valid(n, m);
    check("zero_latency", 80'(n), 80'd64);
    ack();

    // 12345 with mesgul duration
    push(80'h12345, 5'd5, 1'b0);
    pulse(64'd12345, 1'b0);
    wait_valid(n, m);
    check("12345_latency", 80'(n), 80'd64);
    check("12345_mesgul_cycles", 80'(m), 80'd64);
    ack();
    check("12345_bcd_kept", bcd, 80'h12345);

    // Maximum value
    push(80'h18446744073709551615, 5'd20, 1'b0);
    pulse(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_valid(n, m);
    check("max_latency", 80'(n), 80'd64);
    ack();

    // Upstream overflow: result on the capture edge
    push(80'h0, 5'd0, 1'b1);
    pulse(64'd555, 1'b1);
    check("ovf_gecerli", 80'(bcd_gecerli), 80'd1);
    check("ovf_hata", 80'(hata), 80'd1);
    check("ovf_bcd", bcd, 80'd0);
    check("ovf_mesgul", 80'(mesgul), 80'd1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_held", 80'(bcd_gecerli), 80'd1);
    ack();

    // Held level: exactly one conversion
    push(80'h7, 5'd1, 1'b0);
    @(negedge clk);
    sonuc = 64'd7; hazir = 1'b1; gecerli = 1'b1;
    donusum = 0; prev = 1'b0; acked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bcd_gecerli && !prev) donusum++;
      prev = bcd_gecerli;
      alindi = bcd_gecerli && !acked;
      if (alindi) acked = 1'b1;
    end
    alindi = 1'b0; hazir = 1'b0; gecerli = 1'b0;
    check("held_conversions", 80'(donusum), 80'd1);

    // Reset in the middle of a conversion
    pulse(64'd999, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_bcd", bcd, 80'd0);
    check("midrst_anlamli", 80'(anlamli_basamak), 80'd0);
    check("midrst_gecerli", 80'(bcd_gecerli), 80'd0);
    check("midrst_mesgul", 80'(mesgul), 80'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    push(80'h42, 5'd2, 1'b0);
    pulse(64'd42, 1'b0);
    wait_valid(n, m);
    check("42_latency", 80'(n), 80'd64);
    ack();

    repeat (3) @(negedge clk);
    check("queue_empty", 80'(kuyruk.size()), 80'd0);
    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
